// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath definitions: word width, PC mux selects and fetch FSM encoding.
package lc3_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [1:0] SEL_PC_INC = 2'b00;
  localparam logic [1:0] SEL_PC_EAB = 2'b01;
  localparam logic [1:0] SEL_PC_BUS = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StMarld,
    StWait,
    StLdir
  } fetch_state_t;

endpackage

// File: rtl/fetch_wait_counter.sv
// Memory wait counter for instruction fetch: 8-bit saturating, hit when count reaches WAIT_MAX.
module fetch_wait_counter #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam logic [7:0] WaitMax = 8'(WAIT_MAX);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == WaitMax);

endmodule

// File: rtl/instr_fetch.sv
// LC-3 instruction-fetch sequencer: latches PC into MAR, bumps the PC, reads memory, loads IR.
module instr_fetch
  import lc3_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic [WORD_W-1:0] PCOut,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [WORD_W-1:0] mem_addr,
  output logic              mem_req,
  output logic              ldPC,
  output logic [1:0]        selPC,
  output logic [WORD_W-1:0] IR,
  output logic              fetch_done,
  output logic              fetch_err,
  output logic              busy
);

  fetch_state_t state_q, state_d;
  logic [WORD_W-1:0] mar_q, mar_d;
  logic [WORD_W-1:0] mdr_q, mdr_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic cnt_clr, cnt_inc, cnt_hit;

  fetch_wait_counter #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .hit   (cnt_hit)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      mar_q   <= '0;
      mdr_q   <= '0;
      ir_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      ir_q    <= ir_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state plus datapath updates; flush abandons the fetch with no side effects.
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    ir_d    = ir_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StMarld;
            err_d   = 1'b0;
          end
        end
        StMarld: begin
          mar_d   = PCOut;
          cnt_clr = 1'b1;
          state_d = StWait;
        end
        StWait: begin
          if (mem_ready) begin
            mdr_d   = mem_rdata;
            state_d = StLdir;
          end else if (cnt_hit) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        StLdir: begin
          ir_d    = mdr_q;
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    mem_req    = (state_q == StWait);
    ldPC       = (state_q == StMarld) && !flush;
    busy       = (state_q != StIdle);
    selPC      = SEL_PC_INC;
    mem_addr   = mar_q;
    IR         = ir_q;
    fetch_done = done_q;
    fetch_err  = err_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural PC block that increments on ldPC.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset, start, flush, mem_ready;
  logic [15:0] pc_q, pc_wdata, mem_rdata;
  logic        pc_wr;
  logic [15:0] mem_addr, IR;
  logic        mem_req, ldPC, fetch_done, fetch_err, busy;
  logic [1:0]  selPC;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] ir_exp;

  always #5 clk = ~clk;

  instr_fetch #(
    .WAIT_MAX (15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .flush      (flush),
    .PCOut      (pc_q),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_req    (mem_req),
    .ldPC       (ldPC),
    .selPC      (selPC),
    .IR         (IR),
    .fetch_done (fetch_done),
    .fetch_err  (fetch_err),
    .busy       (busy)
  );

  always @(posedge clk) begin
    if (pc_wr) pc_q <= pc_wdata;
    else if (ldPC) pc_q <= pc_q + 16'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [15:0] v);
    pc_wr = 1'b1;
    pc_wdata = v;
    step();
    pc_wr = 1'b0;
  endtask

  // Starts in an IDLE cycle; returns in the fetch_done cycle.
  task automatic fetch(input logic [15:0] exp_addr, input logic [15:0] data, input int waits);
    int req_cycles = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("marld_ldpc", 32'(ldPC), 32'd1);
    check("marld_req", 32'(mem_req), 32'd0);
    check("marld_err_clr", 32'(fetch_err), 32'd0);
    check("done_one_cycle", 32'(fetch_done), 32'd0);
    step();
    check("wait_addr", 32'(mem_addr), 32'(exp_addr));
    check("wait_ldpc", 32'(ldPC), 32'd0);
    check("selpc", 32'(selPC), 32'd0);
    for (int i = 0; i <= waits; i++) begin
      if (mem_req) req_cycles++;
      mem_ready = (i == waits);
      mem_rdata = (i == waits) ? data : 16'hDEAD;
      step();
    end
    mem_ready = 1'b0;
    check("req_cycles", 32'(req_cycles), 32'(waits + 1));
    check("ldir_busy", 32'(busy), 32'd1);
    check("ldir_done", 32'(fetch_done), 32'd0);
    step();
    ir_exp = data;
    check("ir", 32'(IR), 32'(data));
    check("done", 32'(fetch_done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_err", 32'(fetch_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; start = 1'b1; flush = 1'b0; mem_ready = 1'b0;
    mem_rdata = 16'h0; pc_wr = 1'b1; pc_wdata = 16'h3000;
    step();
    step();
    pc_wr = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", {mem_addr, IR}, 32'h0);
    check("rst_flags", {28'd0, mem_req, ldPC, fetch_done, fetch_err}, 32'h0);
    reset = 1'b1;
    start = 1'b0;
    step();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_ir", 32'(IR), 32'h0);

    // Zero-wait fetch, then the same address with three wait cycles.
    fetch(16'h3000, 16'h1261, 0);
    step();
    set_pc(16'h3000);
    fetch(16'h3000, 16'hABCD, 3);
    step();

    // Timeout: 16 WAIT cycles (count 0..15), then abort.
    set_pc(16'h3100);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n = 0;
    while (busy && n < 40) begin
      if (mem_req) n++;
      step();
    end
    check("tmo_req_cycles", 32'(n), 32'd16);
    check("tmo_err", 32'(fetch_err), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_ir", 32'(IR), 32'(ir_exp));
    check("tmo_done", 32'(fetch_done), 32'd0);
    fetch(16'h3101, 16'h5020, 1);
    step();

    // Flush in MARLD suppresses ldPC and the PC increment.
    set_pc(16'h4000);
    start = 1'b1;
    step();
    start = 1'b0;
    flush = 1'b1;
    #1;
    check("flush_ldpc", 32'(ldPC), 32'd0);
    check("flush_busy", 32'(busy), 32'd1);
    step();
    flush = 1'b0;
    check("flush_idle", 32'(busy), 32'd0);
    check("flush_pc", 32'(pc_q), 32'h4000);

    // Flush coincident with mem_ready discards the data.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    mem_ready = 1'b1;
    mem_rdata = 16'hBEEF;
    flush = 1'b1;
    step();
    flush = 1'b0;
    mem_ready = 1'b0;
    check("flrdy_busy", 32'(busy), 32'd0);
    check("flrdy_done", 32'(fetch_done), 32'd0);
    step();
    check("flrdy_ir", 32'(IR), 32'(ir_exp));
    check("flrdy_done2", 32'(fetch_done), 32'd0);

    // Back-to-back: second start issued in the fetch_done cycle.
    set_pc(16'h3000);
    fetch(16'h3000, 16'h1111, 0);
    fetch(16'h3001, 16'h2222, 2);
    step();

    // Reset during WAIT.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("rw_req_before", 32'(mem_req), 32'd1);
    reset = 1'b0;
    step();
    check("rw_req", 32'(mem_req), 32'd0);
    check("rw_ir", 32'(IR), 32'h0);
    reset = 1'b1;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("rw_done", 32'(fetch_done), 32'd0);
    check("rw_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch sequencer for the LC-3 datapath; it is the consumer side of the PC register. On `start` it copies `PCOut` into an internal MAR and drives `ldPC`/`selPC` so the PC block advances. It then runs a request/ready read handshake with instruction memory and loads the returned word into IR. It sits between the control FSM, the PC block and the memory interface, and is the only block that issues PC-increment loads during fetch.

## Interface
Parameters:
- `WAIT_MAX`, default 15: maximum memory wait cycles before a fetch aborts with an error (1..255).

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `start` in 1: fetch request from the control FSM; sampled only in IDLE.
- `flush` in 1: abort any in-progress fetch (redirect); has priority over everything except reset.
- `PCOut` in 16: current PC value from the PC block.
- `mem_rdata` in 16: read data from instruction memory; valid when `mem_ready`=1.
- `mem_ready` in 1: memory read-complete strobe.
- `mem_addr` out 16: read address; equals MAR.
- `mem_req` out 1: read request; high only in WAIT.
- `ldPC` out 1: PC load enable to the PC block.
- `selPC` out 2: PC mux select to the PC block; always 2'b00 (increment).
- `IR` out 16: instruction register.
- `fetch_done` out 1: one-cycle pulse; high in the first cycle in which IR holds the new word.
- `fetch_err` out 1: sticky timeout flag.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States:
  - IDLE: `start`=1 and `flush`=0 -> MARLD.
  - MARLD: MAR <= `PCOut`; `ldPC`=1 unless `flush`=1; -> WAIT.
  - WAIT: `mem_req`=1.
    - `mem_ready`=1: MDR <= `mem_rdata`; -> LDIR.
    - Otherwise, the wait counter increments. When the counter equals `WAIT_MAX` with `mem_ready`=0: `fetch_err` <= 1; -> IDLE.
  - LDIR: IR <= MDR; `fetch_done` <= 1 (registered); -> IDLE.
- `flush`=1 in any state: next state IDLE.
  - No IR update and no `fetch_done`.
  - `ldPC` is forced to 0 combinationally.
  - Flush in the same cycle as `mem_ready` discards the data.
- `start` outside IDLE is ignored; there is no queueing.
- `fetch_err` clears when the next `start` is accepted, in the same edge as entry to MARLD.
- The wait counter is 8 bits. It clears on entry to WAIT and does not wrap, because the timeout fires first.
- `ldPC`, `mem_req` and `busy` are Moore outputs, with `ldPC` additionally gated by `flush`. `mem_addr` = MAR at all times.
- Reset values: state IDLE, MAR=0, MDR=0, IR=16'h0000, counter=0. All outputs 0 (`mem_addr`=16'h0000, `selPC`=2'b00).

## Timing
- `start` high in cycle 0 (IDLE):
  - cycle 1: MARLD, `ldPC`=1.
  - edge ending cycle 1: MAR captures the old PC; the PC block increments.
  - cycle 2: WAIT, `mem_req`=1, `mem_addr`=old PC.
- Zero-wait memory (`mem_ready` in cycle 2): cycle 3 is LDIR; cycle 4 has IR valid, `fetch_done`=1, `busy`=0.
- Each cycle without `mem_ready` in WAIT adds one cycle of latency.
- Back-to-back: `start` high in the `fetch_done` cycle is accepted. The next fetch address is the incremented PC.
- Reset low mid-WAIT: `mem_req` is low from the next cycle. IR returns to 0 and no `fetch_done` occurs.

## Structure
- Shared package `lc3_pkg` holds:
  - state encoding `fetch_state_t`;
  - constants `SEL_PC_INC`=2'b00, `SEL_PC_EAB`=2'b01, `SEL_PC_BUS`=2'b10;
  - `WORD_W`=16.
- Sub-module `fetch_wait_counter`: 8-bit saturating counter with `clr`/`inc` inputs and a `hit` output (count == `WAIT_MAX`).

## Test plan
- Reset low for 2 cycles, then high -> all outputs 0 and state IDLE; `start`=1 during reset is ignored.
- `PCOut`=16'h3000, `start` pulse, `mem_ready` in the first WAIT cycle with `mem_rdata`=16'h1261 -> `ldPC` high exactly cycle 1, `mem_addr`=16'h3000, IR=16'h1261 and `fetch_done` in cycle 4.
- Same fetch with 3 wait cycles, `mem_rdata`=16'hABCD -> `mem_req` high 4 cycles, `fetch_done` in cycle 7, `fetch_err`=0.
- `mem_ready` never asserted, `WAIT_MAX`=15 -> `fetch_err`=1 after 15 wait cycles, `busy` drops, IR unchanged; the next `start` clears `fetch_err`.
- `flush` in MARLD -> `ldPC`=0 that cycle. `flush` coincident with `mem_ready` -> IR unchanged and no `fetch_done`.
- Two back-to-back fetches with PC model 16'h3000 -> 16'h3001 -> addresses 16'h3000 then 16'h3001; `start` in the `fetch_done` cycle is accepted.
